ps2_frame_receiver: RTL and testbench

- Upstream stage of the scancode converter. Deserialises the raw PS/2 device-to-host line pair into bytes.
- Emits each valid byte as an 8-bit value plus a one-cycle strobe, directly compatible with the converter's ps2_rx_stb / ps2_rx_data inputs.
- Synchronises and de-glitches the asynchronous PS/2 clock, checks start, parity and stop bits, and recovers from stalled frames via an inactivity timeout.

---
 rtl/ps2_frame_receiver.sv | 165 ++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host deserialiser: sync + glitch filter + start/data/parity/stop framing.
// Latency: raw ps2_clk fall of the stop bit to ps2_rx_stb is about SYNC_STAGES + FILTER_LEN + 2 cycles.
// Backpressure: none; ps2_rx_stb/ps2_rx_err are single-cycle pulses with no ready input.
module ps2_frame_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_rx_data,
  output logic       ps2_rx_stb,
  output logic       ps2_rx_err,
  output logic       ps2_busy
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0]  data_dly_q, data_dly_d;
  logic [FCW-1:0]         filt_cnt_q, filt_cnt_d;
  logic                   filt_clk_q, filt_clk_d;
  logic                   fall_q, fall_d;
  state_t                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TCW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_stb_q, rx_stb_d;
  logic                   rx_err_q, rx_err_d;
  logic                   busy_q, busy_d;

  logic clk_s;
  logic data_s;
  logic bit_s;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  // Data is delayed by the filter depth so the sampled bit lines up with the filtered edge.
  assign bit_s  = data_dly_q[FILTER_LEN-1];

  // Next-state logic: synchronisers, glitch filter, edge detect, framing FSM and timeout.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    data_dly_d  = {data_dly_q[FILTER_LEN-2:0], data_s};

    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = clk_s;
      end else begin
        filt_cnt_d = filt_cnt_q + FCW'(1);
      end
    end
    fall_d = filt_clk_q & ~filt_clk_d;

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    rx_data_d = rx_data_q;
    rx_stb_d  = 1'b0;
    rx_err_d  = 1'b0;
    tmo_cnt_d = tmo_cnt_q;

    if (fall_q) begin
      // An edge event always wins over a coincident timeout.
      tmo_cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!bit_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {bit_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = bit_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // Odd parity over data+parity and a high stop bit make a good frame.
          if (bit_s && (^{shift_q, parity_q})) begin
            rx_data_d = shift_q;
            rx_stb_d  = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      // Stalled frame: drop it and report once.
      state_d   = IDLE;
      shift_d   = '0;
      tmo_cnt_d = '0;
      rx_err_d  = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TCW'(1);
    end

    busy_d = (state_d != IDLE);
  end

  // State registers; line-side flops reset to the idle-high level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      data_dly_q  <= '1;
      filt_cnt_q  <= '0;
      filt_clk_q  <= 1'b1;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      rx_data_q   <= '0;
      rx_stb_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      data_dly_q  <= data_dly_d;
      filt_cnt_q  <= filt_cnt_d;
      filt_clk_q  <= filt_clk_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_stb_q    <= rx_stb_d;
      rx_err_q    <= rx_err_d;
      busy_q      <= busy_d;
    end
  end

  assign ps2_rx_data = rx_data_q;
  assign ps2_rx_stb  = rx_stb_q;
  assign ps2_rx_err  = rx_err_q;
  assign ps2_busy    = busy_q;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: stimulus pushes expected events, a monitor pops them.
// Uses a shortened timeout so the stalled-frame case stays quick.
// PS/2 bit period is 2*HALF clk cycles.
module tb_ps2_frame_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 8;
  localparam int TMO         = 2000;
  localparam int HALF        = 40;
  localparam int GAP         = 60;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ps2_rx_data;
  logic       ps2_rx_stb;
  logic       ps2_rx_err;
  logic       ps2_busy;

  ps2_frame_receiver #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .ps2_rx_data(ps2_rx_data),
    .ps2_rx_stb(ps2_rx_stb),
    .ps2_rx_err(ps2_rx_err),
    .ps2_busy(ps2_busy)
  );

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_fall = 0;
  logic [7:0] last_good = 8'h00;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_good(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
    last_good = d;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    exp_q.push_back(e);
  endtask

  // One PS/2 bit: data set at start of the high phase, then a falling clock edge.
  task automatic ps2_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      wait_clks(15);
      ps2_clk = 1'b0;
      wait_clks(3);
      ps2_clk = 1'b1;
      wait_clks(HALF - 18);
    end else begin
      wait_clks(HALF);
    end
    ps2_clk   = 1'b0;
    last_fall = cyc;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop,
                            input logic glitch, input logic chk_busy);
    logic par;
    par = ~(^d) ^ bad_par;
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) begin
      ps2_bit(d[i], glitch);
      if (chk_busy && i == 3) check("busy_mid_frame", ps2_busy, 1);
    end
    ps2_bit(par, glitch);
    if (chk_busy) check("busy_before_stop", ps2_busy, 1);
    ps2_bit(stop, glitch);
    ps2_data = 1'b1;
    wait_clks(GAP);
  endtask

  // Monitor: every strobe or error pops one expected event.
  always @(negedge clk) begin
    if (rst_n && (ps2_rx_stb || ps2_rx_err)) begin
      check("stb_err_exclusive", {31'b0, ps2_rx_stb & ps2_rx_err}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: stb=%0b err=%0b data=0x%0h with nothing expected",
                 ps2_rx_stb, ps2_rx_err, ps2_rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_is_err", {31'b0, ps2_rx_err}, {31'b0, mon_e.is_err});
        check("event_rx_data", {24'b0, ps2_rx_data}, {24'b0, mon_e.data});
      end
    end
  end

  // Watchdog keeps the run bounded whatever the DUT does.
  initial begin
    repeat (80000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: run exceeded cycle budget");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int  dly;
    bool_seen_t: begin end
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_clks(3);
    check("reset_rx_data", {24'b0, ps2_rx_data}, 0);
    check("reset_rx_stb", {31'b0, ps2_rx_stb}, 0);
    check("reset_rx_err", {31'b0, ps2_rx_err}, 0);
    check("reset_busy", {31'b0, ps2_busy}, 0);
    rst_n = 1'b1;
    wait_clks(20);

    // Single good frame with busy checks.
    push_good(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1);
    check("busy_after_frame", {31'b0, ps2_busy}, 0);

    // Back-to-back frames.
    push_good(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_good(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);

    // Inverted parity, then a low stop bit: both report an error and keep the old byte.
    push_err();
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    push_err();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stalled frame: start plus three data bits, then the clock stays high.
    push_err();
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    dly = -1;
    for (int i = 0; i < TMO + 200; i++) begin
      @(negedge clk);
      if (ps2_rx_err) begin
        dly = cyc - last_fall;
        break;
      end
    end
    checks++;
    if (dly < TMO + 9 || dly > TMO + 13) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles after last edge, expected %0d..%0d",
               dly, TMO + 9, TMO + 13);
    end
    wait_clks(2);
    check("busy_after_timeout", {31'b0, ps2_busy}, 0);
    wait_clks(GAP);
    push_good(8'h29);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b0);

    // Short clock glitches during every bit of a frame are filtered out.
    push_good(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);

    // A glitch on an idle line never starts a frame.
    ps2_clk = 1'b0;
    wait_clks(3);
    ps2_clk = 1'b1;
    begin
      logic busy_seen;
      busy_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        busy_seen = busy_seen | ps2_busy;
      end
      check("idle_glitch_busy", {31'b0, busy_seen}, 0);
    end

    // Reset in the middle of a frame, after its parity bit.
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(dly[0] ^ dly[0] ^ ((8'h45 >> i) & 1) != 0, 1'b0);
    ps2_bit(1'b0, 1'b0);
    wait_clks(5);
    rst_n = 1'b0;
    #1;
    check("midreset_rx_data", {24'b0, ps2_rx_data}, 0);
    check("midreset_busy", {31'b0, ps2_busy}, 0);
    check("midreset_stb", {31'b0, ps2_rx_stb}, 0);
    check("midreset_err", {31'b0, ps2_rx_err}, 0);
    wait_clks(2);
    rst_n     = 1'b1;
    last_good = 8'h00;
    // Stray stop-bit edge lands in IDLE with data high and is ignored.
    ps2_bit(1'b1, 1'b0);
    wait_clks(30);
    check("busy_after_stray_stop", {31'b0, ps2_busy}, 0);
    push_good(8'h45);
    send_frame(8'h45, 1'b0, 1'b1, 1'b0, 1'b0);

    wait_clks(200);
    check("scoreboard_drained", exp_q.size(), 0);
    check("final_rx_data", {24'b0, ps2_rx_data}, 32'h45);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
